norm32_seq: RTL and testbench
=============================

Name: norm32_seq

Overview:
- Sequential 32-bit normalizer; the inverse of the barrel shifter.
- Given a data word, it finds the shift amount that brings the first set bit to the word edge and applies that shift.
- LnR=1 counts leading zeros and normalizes left (MSB set); LnR=0 counts trailing zeros and normalizes right (LSB set).
- Used by the ALU/FPU datapath for CLZ/CTZ and mantissa normalization; binary search, one stage per clock (16, 8, 4, 2, 1).

Parameters:
- None. Width fixed at 32, count width fixed at 6.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  synchronous reset, active-high
- START  input  1  request pulse; sampled only in IDLE
- D  input  32  data word, captured with START
- LnR  input  1  direction, captured with START; 1 = left/leading zeros, 0 = right/trailing zeros
- Y  output  32  normalized word
- CNT  output  6  shift amount applied, 0..32
- ZERO  output  1  captured D was all zeros
- BUSY  output  1  high whenever state is not IDLE
- DONE  output  1  one-cycle result-valid strobe

Behaviour:
- Clocking and reset: one clock (CLK); reset RST is synchronous and active-high.
- Reset values: state=IDLE; Y=0, CNT=0, ZERO=0, BUSY=0, DONE=0. Internal working register, counter and stage index also clear.
- FSM states: IDLE, SCAN, DONE_S.
- IDLE to SCAN (edge E0, START=1):
  - capture D into work register W and LnR into a direction flag
  - set cnt=0, stage index k=4
  - set zero flag = (D==0)
- SCAN, one stage per edge E1..E5, step s = 2^k, k = 4, 3, 2, 1, 0:
  - left: if W[31:32-s]==0, then W <= W<<s and cnt += s
  - right: if W[s-1:0]==0, then W <= W>>s and cnt += s
  - zero fill on all shifts; k decrements each edge
  - at E5 (k=0 stage), go to DONE_S and load Y/CNT/ZERO from the final values
- DONE_S: DONE=1 for exactly one cycle; the next edge returns to IDLE.
- Fixed latency: START sampled at E0 gives DONE high in the cycle after E5, i.e. 6 edges from acceptance. This is independent of data, including zero input.
- Zero input: binary search yields cnt=31; it is overridden so that CNT=32, Y=0, ZERO=1.
- Output hold: Y, CNT and ZERO hold their values until the DONE_S load of the next operation. They are not cleared on return to IDLE. They are not updated during SCAN (internal W/cnt only).
- BUSY=1 in SCAN and DONE_S.
- START outside IDLE (SCAN or DONE_S) is ignored. No queueing; the operation in flight is unaffected. Earliest back-to-back acceptance is the edge following the DONE cycle.
- D and LnR changes after E0 have no effect.
- RST mid-operation: state returns to IDLE at that edge, all outputs clear, no DONE strobe. START coincident with RST is ignored.
- Arithmetic: cnt is 6 bits; maximum reachable before the zero override is 31, so there is no overflow.
- Invariant (D≠0):
  - left: Y == D<<CNT and Y[31]==1
  - right: Y == D>>CNT and Y[0]==1

Test Plan:
- Left, D=0x00000001, START one cycle -> BUSY high 6 cycles; DONE one cycle after 6th edge; Y=0x80000000, CNT=31, ZERO=0.
- Left, D=0x00F00000 -> Y=0xF0000000, CNT=8. Right, D=0x00F00000 -> Y=0x0000000F, CNT=20.
- D=0x00000000, both LnR values -> Y=0x00000000, CNT=32, ZERO=1; same 6-cycle latency.
- Left, D=0x80000000 -> Y=0x80000000, CNT=0. Right, D=0x00000001 -> CNT=0.
- Collisions: start D=0x00010000 left; pulse START with D=0xFFFFFFFF at cycles 2 and during DONE -> both ignored; result Y=0x80000000, CNT=15; next START accepted after DONE.
- Reset: start D=0x00000100 left; assert RST at cycle 3 -> outputs 0, BUSY=0, no DONE. Then new START D=0x00000100 right -> Y=0x00000001, CNT=8.

Source files
------------

// File: rtl/norm32_seq.sv
// norm32_seq: sequential 32-bit CLZ/CTZ normalizer using a binary search with one stage per clock
module norm32_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] D,
  input  logic        LnR,
  output logic [31:0] Y,
  output logic [5:0]  CNT,
  output logic        ZERO,
  output logic        BUSY,
  output logic        DONE
);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE_S = 2'd2;
  logic [1:0]  state;
  logic [31:0] w, w_nx;
  logic [5:0]  cnt, cnt_nx, s;
  logic [2:0]  k;
  logic        dir, zf, hit;
  always_comb begin
    s = 6'd1 << k;
    hit = dir ? (w & ~(32'hFFFF_FFFF >> s)) == 32'd0 : (w & ~(32'hFFFF_FFFF << s)) == 32'd0;
    w_nx = hit ? (dir ? w << s : w >> s) : w;
    cnt_nx = hit ? cnt + s : cnt;
  end
  assign BUSY = state != IDLE;
  assign DONE = state == DONE_S;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      w <= '0;
      cnt <= '0;
      k <= '0;
      dir <= 1'b0;
      zf <= 1'b0;
      Y <= '0;
      CNT <= '0;
      ZERO <= 1'b0;
    end else if (state == IDLE) begin
      if (START) begin
        state <= SCAN;
        w <= D;
        dir <= LnR;
        cnt <= '0;
        k <= 3'd4;
        zf <= D == 32'd0;
      end
    end else if (state == SCAN) begin
      w <= w_nx;
      cnt <= cnt_nx;
      k <= k - 3'd1;
      if (k == 3'd0) begin
        // an all-zero word ends the search at 31; report it as a full 32-bit shift
        state <= DONE_S;
        Y <= zf ? 32'd0 : w_nx;
        CNT <= zf ? 6'd32 : cnt_nx;
        ZERO <= zf;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_norm32_seq.sv
// tb_norm32_seq: directed checks of latency, results, collisions and reset for norm32_seq
module tb_norm32_seq;
  logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, LnR = 1'b0;
  logic [31:0] D = '0, Y;
  logic [5:0]  CNT;
  logic        ZERO, BUSY, DONE;
  int total = 0, bad = 0;

  norm32_seq dut (.CLK(CLK), .RST(RST), .START(START), .D(D), .LnR(LnR),
                  .Y(Y), .CNT(CNT), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input logic [31:0] d, input logic l,
                    input logic [31:0] ey, input logic [5:0] ec, input logic ez);
    @(negedge CLK);
    START = 1'b1; D = d; LnR = l;
    @(negedge CLK);
    START = 1'b0; D = $urandom; LnR = ~l;
    for (int i = 1; i <= 6; i++) begin
      chk({tag, "_busy"}, 32'(BUSY), 32'd1);
      chk({tag, "_done"}, 32'(DONE), 32'(i == 6));
      if (i < 6) @(negedge CLK);
    end
    chk({tag, "_y"}, Y, ey);
    chk({tag, "_cnt"}, 32'(CNT), 32'(ec));
    chk({tag, "_zero"}, 32'(ZERO), 32'(ez));
    @(negedge CLK);
    chk({tag, "_idle"}, 32'(BUSY), 32'd0);
    chk({tag, "_hold"}, 32'(CNT), 32'(ec));
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_y", Y, 32'd0);
    chk("rst_cnt", 32'(CNT), 32'd0);
    chk("rst_flags", {29'd0, ZERO, BUSY, DONE}, 32'd0);
    RST = 1'b0;
    op("l1", 32'h0000_0001, 1'b1, 32'h8000_0000, 6'd31, 1'b0);
    op("lf0", 32'h00F0_0000, 1'b1, 32'hF000_0000, 6'd8, 1'b0);
    op("rf0", 32'h00F0_0000, 1'b0, 32'h0000_000F, 6'd20, 1'b0);
    op("zl", 32'h0000_0000, 1'b1, 32'h0000_0000, 6'd32, 1'b1);
    op("zr", 32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1);
    op("lmsb", 32'h8000_0000, 1'b1, 32'h8000_0000, 6'd0, 1'b0);
    op("rlsb", 32'h0000_0001, 1'b0, 32'h0000_0001, 6'd0, 1'b0);
    op("rmix", 32'h0A00_5000, 1'b0, 32'h0000_A005, 6'd12, 1'b0);
    // collisions: START during SCAN and during the DONE cycle are both ignored
    @(negedge CLK);
    START = 1'b1; D = 32'h0001_0000; LnR = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    START = 1'b1; D = 32'hFFFF_FFFF;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    chk("col_done_early", 32'(DONE), 32'd0);
    @(negedge CLK);
    chk("col_done", 32'(DONE), 32'd1);
    chk("col_y", Y, 32'h8000_0000);
    chk("col_cnt", 32'(CNT), 32'd15);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("col_ignored", 32'(BUSY), 32'd0);
    op("col_next", 32'h0000_0100, 1'b0, 32'h0000_0001, 6'd8, 1'b0);
    // reset mid-operation, with START held alongside RST
    @(negedge CLK);
    START = 1'b1; D = 32'h0000_0100; LnR = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1; START = 1'b1;
    @(negedge CLK);
    chk("mrst_y", Y, 32'd0);
    chk("mrst_cnt", 32'(CNT), 32'd0);
    chk("mrst_flags", {29'd0, ZERO, BUSY, DONE}, 32'd0);
    RST = 1'b0; START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("mrst_nodone", 32'(DONE | BUSY), 32'd0);
    end
    op("post_rst", 32'h0000_0100, 1'b0, 32'h0000_0001, 6'd8, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
